// File: rtl/wash_cycle_controller_if.sv
// Signal bundle between the wash-cycle controller and its sensors/actuators.
// The master side drives the sensor/user inputs; the controller is the slave.
interface wash_cycle_controller_if #(
    parameter int RCNT_W = 3
);
    logic              door_close_i;
    logic              start_i;
    logic              filled_i;
    logic              detergent_added_i;
    logic              drained_i;
    logic              abort_i;
    logic              pause_i;
    logic              door_lock_o;
    logic              motor_on_o;
    logic              fill_valve_on_o;
    logic              drain_valve_on_o;
    logic              soap_wash_o;
    logic              water_wash_o;
    logic              done_o;
    logic              fault_o;
    logic [3:0]        state_out_o;
    logic [RCNT_W-1:0] rinse_count_o;

    modport master (
        output door_close_i, start_i, filled_i, detergent_added_i, drained_i, abort_i, pause_i,
        input  door_lock_o, motor_on_o, fill_valve_on_o, drain_valve_on_o, soap_wash_o,
               water_wash_o, done_o, fault_o, state_out_o, rinse_count_o
    );

    modport slave (
        input  door_close_i, start_i, filled_i, detergent_added_i, drained_i, abort_i, pause_i,
        output door_lock_o, motor_on_o, fill_valve_on_o, drain_valve_on_o, soap_wash_o,
               water_wash_o, done_o, fault_o, state_out_o, rinse_count_o
    );
endinterface

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: soap wash, NUM_RINSES rinse passes, timed spin, with
// fill watchdog, user abort and door fault. Define WCC_PAUSE_EN to enable pause/freeze.
module wash_cycle_controller #(
    parameter int TIMER_W      = 16,
    parameter int WASH_TICKS   = 1000,
    parameter int RINSE_TICKS  = 500,
    parameter int SPIN_TICKS   = 800,
    parameter int NUM_RINSES   = 2,
    parameter int RCNT_W       = 3,
    parameter int FILL_TIMEOUT = 2000
) (
    input logic                    clk,
    input logic                    reset,
    wash_cycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FILL  = 4'd1,
        DET   = 4'd2,
        WASH  = 4'd3,
        DRAIN = 4'd4,
        RINSE = 4'd5,
        SPIN  = 4'd6,
        DONE  = 4'd7,
        FAULT = 4'd8
    } state_t;

    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
    localparam logic [RCNT_W-1:0]  NUM_R      = RCNT_W'(NUM_RINSES);

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                abort_q, abort_d;
    logic                rinse_phase_q, rinse_phase_d;
    logic                lock_q, lock_d;
    logic                motor_q, motor_d;
    logic                fill_q, fill_d;
    logic                drain_q, drain_d;
    logic                soap_q, soap_d;
    logic                water_q, water_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                locked;
    logic                abortable;
    logic                paused;
    logic                freeze;

    assign locked    = state_q inside {FILL, DET, WASH, DRAIN, RINSE, SPIN};
    assign abortable = state_q inside {FILL, DET, WASH, RINSE, SPIN};

`ifdef WCC_PAUSE_EN
    assign paused = bus.pause_i && (state_q inside {WASH, RINSE, SPIN});
`else
    logic unused_pause;
    assign unused_pause = bus.pause_i;
    assign paused       = 1'b0;
`endif

    // Sequencing first, then abort overrides it and a door fault overrides everything.
    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        rcnt_d        = rcnt_q;
        rinse_phase_d = rinse_phase_q;
        case (state_q)
            IDLE: if (bus.start_i && bus.door_close_i) state_d = FILL;
            FILL: begin
                if (bus.filled_i)              state_d = rinse_phase_q ? RINSE : DET;
                else if (timer_q == FILL_LAST) state_d = FAULT;
            end
            DET:  if (bus.detergent_added_i) state_d = WASH;
            WASH: if (!paused && timer_q == WASH_LAST) state_d = DRAIN;
            RINSE: begin
                if (!paused && timer_q == RINSE_LAST) begin
                    state_d = DRAIN;
                    rcnt_d  = rcnt_q + RCNT_W'(1);
                end
            end
            DRAIN: begin
                if (bus.abort_i) abort_d = 1'b1;
                if (bus.drained_i) begin
                    if (abort_q || bus.abort_i) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                        rcnt_d  = '0;
                    end else if (rcnt_q < NUM_R) begin
                        state_d       = FILL;
                        rinse_phase_d = 1'b1;
                    end else begin
                        state_d = SPIN;
                    end
                end
            end
            SPIN: if (!paused && timer_q == SPIN_LAST) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase

        if (abortable && bus.abort_i) begin
            state_d = DRAIN;
            abort_d = 1'b1;
            rcnt_d  = rcnt_q;
        end

        if (locked && !bus.door_close_i) begin
            state_d       = FAULT;
            abort_d       = abort_q;
            rcnt_d        = rcnt_q;
            rinse_phase_d = rinse_phase_q;
        end

        if (state_d == IDLE) rinse_phase_d = 1'b0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    assign freeze = paused && (state_d == state_q);

    always_comb begin
        timer_d = '0;
        if (state_d == state_q) timer_d = paused ? timer_q : timer_q + TIMER_W'(1);
        lock_d  = state_d inside {FILL, DET, WASH, DRAIN, RINSE, SPIN, FAULT};
        motor_d = (state_d inside {WASH, RINSE, SPIN}) && !freeze;
        fill_d  = (state_d == FILL);
        drain_d = (state_d inside {DRAIN, FAULT}) || (state_d == SPIN && !freeze);
        soap_d  = !rinse_phase_d && (state_d inside {FILL, DET, WASH, DRAIN});
        water_d = (state_d == SPIN) || (rinse_phase_d && (state_d inside {FILL, RINSE, DRAIN}));
        done_d  = (state_d == DONE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rcnt_q        <= '0;
            abort_q       <= 1'b0;
            rinse_phase_q <= 1'b0;
            lock_q        <= 1'b0;
            motor_q       <= 1'b0;
            fill_q        <= 1'b0;
            drain_q       <= 1'b0;
            soap_q        <= 1'b0;
            water_q       <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rcnt_q        <= rcnt_d;
            abort_q       <= abort_d;
            rinse_phase_q <= rinse_phase_d;
            lock_q        <= lock_d;
            motor_q       <= motor_d;
            fill_q        <= fill_d;
            drain_q       <= drain_d;
            soap_q        <= soap_d;
            water_q       <= water_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.door_lock_o      = lock_q;
    assign bus.motor_on_o       = motor_q;
    assign bus.fill_valve_on_o  = fill_q;
    assign bus.drain_valve_on_o = drain_q;
    assign bus.soap_wash_o      = soap_q;
    assign bus.water_wash_o     = water_q;
    assign bus.done_o           = done_q;
    assign bus.fault_o          = fault_q;
    assign bus.state_out_o      = state_q;
    assign bus.rinse_count_o    = rcnt_q;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// Testbench for wash_cycle_controller: expected behaviour is planned as a list of
// phase segments (state, length, flags) and every cycle is compared against it.
module tb_wash_cycle_controller;
    localparam int WASH_T   = 4;
    localparam int RINSE_T  = 3;
    localparam int SPIN_T   = 5;
    localparam int FILL_TO  = 10;

    localparam int S_IDLE = 0, S_FILL = 1, S_DET = 2, S_WASH = 3, S_DRAIN = 4;
    localparam int S_RINSE = 5, S_SPIN = 6, S_DONE = 7, S_FAULT = 8;

    localparam int A_NONE = 0, A_FILLED = 1, A_DET = 2, A_DRAINED = 3;
    localparam int A_ABORT = 4, A_DOOR = 5, A_START = 6, A_RESET = 7;

    typedef struct {
        int st;
        int len;
        int rc;
        bit soap;
        bit water;
        int act;
        int pmask;
    } seg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, sel;
    logic doorClose, start, filled, detergent, drained, abort, pause;
    logic rstA, rstB;
    int   vectors = 0;
    int   miscompares = 0;
    seg_t plan[$];

    wash_cycle_controller_if #(.RCNT_W(3)) ifA ();
    wash_cycle_controller_if #(.RCNT_W(3)) ifB ();

    assign rstA = rstN && !sel;
    assign rstB = rstN && sel;

    assign ifA.door_close_i = doorClose;        assign ifB.door_close_i = doorClose;
    assign ifA.start_i = start;                 assign ifB.start_i = start;
    assign ifA.filled_i = filled;               assign ifB.filled_i = filled;
    assign ifA.detergent_added_i = detergent;   assign ifB.detergent_added_i = detergent;
    assign ifA.drained_i = drained;             assign ifB.drained_i = drained;
    assign ifA.abort_i = abort;                 assign ifB.abort_i = abort;
    assign ifA.pause_i = pause;                 assign ifB.pause_i = pause;

    wash_cycle_controller #(
        .TIMER_W(8), .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T), .SPIN_TICKS(SPIN_T),
        .NUM_RINSES(2), .RCNT_W(3), .FILL_TIMEOUT(FILL_TO)
    ) dutA (.clk(clk), .reset(rstA), .bus(ifA));

    wash_cycle_controller #(
        .TIMER_W(8), .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T), .SPIN_TICKS(SPIN_T),
        .NUM_RINSES(0), .RCNT_W(3), .FILL_TIMEOUT(FILL_TO)
    ) dutB (.clk(clk), .reset(rstB), .bus(ifB));

    logic [3:0] obsState;
    logic [7:0] obsOut;
    logic [2:0] obsCount;

    assign obsState = sel ? ifB.state_out_o : ifA.state_out_o;
    assign obsCount = sel ? ifB.rinse_count_o : ifA.rinse_count_o;
    assign obsOut   = sel ?
        {ifB.door_lock_o, ifB.motor_on_o, ifB.fill_valve_on_o, ifB.drain_valve_on_o,
         ifB.soap_wash_o, ifB.water_wash_o, ifB.done_o, ifB.fault_o} :
        {ifA.door_lock_o, ifA.motor_on_o, ifA.fill_valve_on_o, ifA.drain_valve_on_o,
         ifA.soap_wash_o, ifA.water_wash_o, ifA.done_o, ifA.fault_o};

    function automatic seg_t mk(input int st, input int len, input int rc,
                                input bit soap, input bit water, input int act);
        seg_t s;
        s.st = st; s.len = len; s.rc = rc; s.soap = soap; s.water = water;
        s.act = act; s.pmask = 0;
        return s;
    endfunction

    function automatic int rd();
        return int'($urandom_range(1, 4));
    endfunction

    // Actuator table per phase; a paused spin cycle drops motor and drain.
    function automatic logic [7:0] expectOut(input seg_t s, input int off);
        logic lock, motor, fillV, drainV, frozen;
        frozen = (off > 0) && (((s.pmask >> (off - 1)) & 1) != 0);
        lock   = !(s.st == S_IDLE || s.st == S_DONE);
        motor  = (s.st == S_WASH || s.st == S_RINSE || s.st == S_SPIN) && !frozen;
        fillV  = (s.st == S_FILL);
        drainV = (s.st == S_DRAIN || s.st == S_FAULT || (s.st == S_SPIN && !frozen));
        return {lock, motor, fillV, drainV, s.soap, s.water, s.st == S_DONE, s.st == S_FAULT};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input seg_t s, input int off);
        rstN      = 1'b1;
        filled    = 1'($urandom_range(0, 1));
        detergent = 1'($urandom_range(0, 1));
        drained   = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        pause     = 1'($urandom_range(0, 1));
        abort     = 1'b0;
        doorClose = 1'b1;
        case (s.st)
            S_IDLE: begin
                start     = 1'b0;
                abort     = 1'($urandom_range(0, 1));
                doorClose = 1'($urandom_range(0, 1));
            end
            S_DONE, S_FAULT: begin
                abort     = 1'($urandom_range(0, 1));
                doorClose = 1'($urandom_range(0, 1));
            end
            S_FILL:  filled = 1'b0;
            S_DET:   detergent = 1'b0;
            S_DRAIN: drained = 1'b0;
            default: ;
        endcase
`ifdef WCC_PAUSE_EN
        if (s.st == S_WASH || s.st == S_RINSE || s.st == S_SPIN)
            pause = ((s.pmask >> off) & 1) != 0;
`endif
        if (off == s.len - 1) begin
            case (s.act)
                A_FILLED:  filled = 1'b1;
                A_DET:     detergent = 1'b1;
                A_DRAINED: drained = 1'b1;
                A_ABORT:   abort = 1'b1;
                A_DOOR:    begin doorClose = 1'b0; abort = 1'b1; end
                A_START:   begin start = 1'b1; doorClose = 1'b1; end
                A_RESET:   rstN = 1'b0;
                default:   ;
            endcase
        end
    endtask

    task automatic runPlan();
        string tag;
        foreach (plan[i]) begin
            for (int off = 0; off < plan[i].len; off++) begin
                @(negedge clk);
                tag = $sformatf("dut%0d_seg%0d_st%0d_c%0d", sel, i, plan[i].st, off);
                checkOutput({tag, "_state"}, 32'(obsState), plan[i].st);
                checkOutput({tag, "_outs"}, 32'(obsOut), 32'(expectOut(plan[i], off)));
                if (plan[i].rc >= 0) checkOutput({tag, "_rcnt"}, 32'(obsCount), plan[i].rc);
                applyStimulus(plan[i], off);
            end
        end
        plan.delete();
    endtask

    // Normal cycle; SPIN is stretched by nPause frozen cycles when pause is compiled in.
    task automatic buildFullRun(input int numR, input int nPause);
        seg_t spin;
        int   len;
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, rd(), 0, 1, 0, A_FILLED));
        plan.push_back(mk(S_DET, rd(), 0, 1, 0, A_DET));
        plan.push_back(mk(S_WASH, WASH_T, 0, 1, 0, A_NONE));
        plan.push_back(mk(S_DRAIN, rd(), 0, 1, 0, A_DRAINED));
        for (int r = 0; r < numR; r++) begin
            plan.push_back(mk(S_FILL, rd(), r, 0, 1, A_FILLED));
            plan.push_back(mk(S_RINSE, RINSE_T, r, 0, 1, A_NONE));
            plan.push_back(mk(S_DRAIN, rd(), r + 1, 0, 1, A_DRAINED));
        end
        spin = mk(S_SPIN, SPIN_T, numR, 0, 1, A_NONE);
`ifdef WCC_PAUSE_EN
        len = SPIN_T + nPause;
        spin.len = len;
        while ($countones(spin.pmask) < nPause)
            spin.pmask = spin.pmask | (1 << $urandom_range(0, len - 2));
`else
        len = nPause;
`endif
        plan.push_back(spin);
        plan.push_back(mk(S_DONE, 1, numR, 0, 0, A_NONE));
        plan.push_back(mk(S_IDLE, 2, 0, 0, 0, A_NONE));
    endtask

    initial begin
        rstN = 1'b0; sel = 1'b0;
        doorClose = 1'b1; start = 1'b0; filled = 1'b0; detergent = 1'b0;
        drained = 1'b0; abort = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);

        // Full cycle with three pause cycles in SPIN (ignored without WCC_PAUSE_EN).
        buildFullRun(2, 3);
        runPlan();

        // Abort on the second WASH cycle, then drain back to IDLE without done.
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, rd(), 0, 1, 0, A_FILLED));
        plan.push_back(mk(S_DET, rd(), 0, 1, 0, A_DET));
        plan.push_back(mk(S_WASH, 2, 0, 1, 0, A_ABORT));
        plan.push_back(mk(S_DRAIN, rd(), 0, 1, 0, A_DRAINED));
        plan.push_back(mk(S_IDLE, 2, 0, 0, 0, A_NONE));
        runPlan();

        // A following run must not see the old abort.
        buildFullRun(2, int'($urandom_range(0, 2)));
        runPlan();

        // Fill watchdog: FAULT after 10 FILL cycles, held until reset.
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, FILL_TO, 0, 1, 0, A_NONE));
        plan.push_back(mk(S_FAULT, 6, 0, 0, 0, A_RESET));
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_NONE));
        runPlan();

        // Door opens in RINSE together with an abort: FAULT wins.
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, rd(), 0, 1, 0, A_FILLED));
        plan.push_back(mk(S_DET, rd(), 0, 1, 0, A_DET));
        plan.push_back(mk(S_WASH, WASH_T, 0, 1, 0, A_NONE));
        plan.push_back(mk(S_DRAIN, rd(), 0, 1, 0, A_DRAINED));
        plan.push_back(mk(S_FILL, rd(), 0, 0, 1, A_FILLED));
        plan.push_back(mk(S_RINSE, 2, 0, 0, 1, A_DOOR));
        plan.push_back(mk(S_FAULT, 4, -1, 0, 0, A_RESET));
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_NONE));
        runPlan();

        // Reset in the middle of a rinse, then a clean soap-phase run.
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, rd(), 0, 1, 0, A_FILLED));
        plan.push_back(mk(S_DET, rd(), 0, 1, 0, A_DET));
        plan.push_back(mk(S_WASH, WASH_T, 0, 1, 0, A_NONE));
        plan.push_back(mk(S_DRAIN, rd(), 0, 1, 0, A_DRAINED));
        plan.push_back(mk(S_FILL, rd(), 0, 0, 1, A_FILLED));
        plan.push_back(mk(S_RINSE, 2, 0, 0, 1, A_RESET));
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_NONE));
        buildFullRun(2, 0);
        runPlan();

        // Second instance without rinse passes: first drain goes straight to SPIN.
        sel = 1'b1;
        buildFullRun(0, int'($urandom_range(0, 3)));
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_START));
        plan.push_back(mk(S_FILL, FILL_TO, 0, 1, 0, A_DOOR));
        plan.push_back(mk(S_FAULT, 3, 0, 0, 0, A_RESET));
        plan.push_back(mk(S_IDLE, 1, 0, 0, 0, A_NONE));
        runPlan();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
